// File: rtl/prog_fetch_unit.sv
// rtl/prog_fetch_unit.sv - program-memory fetch unit with 1/2-word decode, redirect and skip
module prog_fetch_unit #(
    parameter int          PC_WIDTH     = 14,
    parameter int unsigned RESET_VECTOR = 0,
    parameter bit          EXT_WORD_EN  = 1'b1,
    parameter int          OFFSET_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    mem_rd_en,
    output logic [PC_WIDTH-1:0]     mem_addr,
    input  logic [15:0]             mem_rdata,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [15:0]             instruction,
    output logic [15:0]             instr_ext,
    output logic                    instr_two_word,
    output logic [PC_WIDTH-1:0]     instr_pc,
    input  logic                    skip_next,
    input  logic                    redirect,
    input  logic                    redirect_rel,
    input  logic [PC_WIDTH-1:0]     redirect_addr,
    input  logic [OFFSET_WIDTH-1:0] redirect_off,
    output logic [PC_WIDTH-1:0]     program_counter
);

    localparam logic [PC_WIDTH-1:0] L_RST_PC = RESET_VECTOR[PC_WIDTH-1:0];
    localparam logic [PC_WIDTH-1:0] L_ONE    = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] L_TWO    = PC_WIDTH'(2);

    typedef enum logic [2:0] {
        ST_ISSUE,
        ST_WAIT1,
        ST_WAIT2,
        ST_VALID,
        ST_SKIP1,
        ST_SKIP2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [15:0]         r_instr;
    logic [15:0]         w_instr_nxt;
    logic [15:0]         r_ext;
    logic [15:0]         w_ext_nxt;
    logic                r_two;
    logic                w_two_nxt;
    logic [PC_WIDTH-1:0] r_instr_pc;
    logic [PC_WIDTH-1:0] w_instr_pc_nxt;
    logic                w_rd_en;
    logic [PC_WIDTH-1:0] w_addr;
    logic                w_rdata_two;
    logic [PC_WIDTH-1:0] w_off_sx;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_len;

    // JMP/CALL share 1001_010x_xxxx_11xx; LDS/STS share 1001_00xx_xxxx_0000
    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
    endfunction

    assign w_rdata_two = EXT_WORD_EN && is_two_word(mem_rdata);
    assign w_off_sx    = PC_WIDTH'(signed'(redirect_off));
    assign w_target    = redirect_rel ? (r_instr_pc + L_ONE + w_off_sx) : redirect_addr;
    assign w_len       = r_two ? L_TWO : L_ONE;

    // State and datapath register update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_ISSUE;
            r_pc       <= L_RST_PC;
            r_instr    <= 16'h0000;
            r_ext      <= 16'h0000;
            r_two      <= 1'b0;
            r_instr_pc <= L_RST_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_ext      <= w_ext_nxt;
            r_two      <= w_two_nxt;
            r_instr_pc <= w_instr_pc_nxt;
        end
    end

    // Next-state, memory request and latch decisions; redirect overrides everything
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_ext_nxt      = r_ext;
        w_two_nxt      = r_two;
        w_instr_pc_nxt = r_instr_pc;
        w_rd_en        = 1'b0;
        w_addr         = r_pc;
        unique case (r_state)
            ST_ISSUE: begin
                w_rd_en     = 1'b1;
                w_state_nxt = ST_WAIT1;
            end
            ST_WAIT1: begin
                w_instr_nxt    = mem_rdata;
                w_ext_nxt      = 16'h0000;
                w_two_nxt      = 1'b0;
                w_instr_pc_nxt = r_pc;
                if (w_rdata_two) begin
                    w_rd_en     = 1'b1;
                    w_addr      = r_pc + L_ONE;
                    w_state_nxt = ST_WAIT2;
                end else begin
                    w_state_nxt = ST_VALID;
                end
            end
            ST_WAIT2: begin
                w_ext_nxt   = mem_rdata;
                w_two_nxt   = 1'b1;
                w_state_nxt = ST_VALID;
            end
            ST_VALID: begin
                if (instr_ready) begin
                    w_pc_nxt = r_pc + w_len;
                    if (skip_next) begin
                        // start the skipped fetch immediately so SKIP1 sees its data
                        w_rd_en     = 1'b1;
                        w_addr      = w_pc_nxt;
                        w_state_nxt = ST_SKIP1;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_SKIP1: begin
                if (w_rdata_two) begin
                    w_rd_en     = 1'b1;
                    w_addr      = r_pc + L_ONE;
                    w_state_nxt = ST_SKIP2;
                end else begin
                    w_pc_nxt    = r_pc + L_ONE;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_SKIP2: begin
                w_pc_nxt    = r_pc + L_TWO;
                w_state_nxt = ST_ISSUE;
            end
            default: begin
                w_state_nxt = ST_ISSUE;
            end
        endcase
        if (redirect) begin
            w_state_nxt    = ST_ISSUE;
            w_pc_nxt       = w_target;
            w_instr_nxt    = r_instr;
            w_ext_nxt      = r_ext;
            w_two_nxt      = r_two;
            w_instr_pc_nxt = r_instr_pc;
            w_rd_en        = 1'b0;
        end
    end

    // no read strobe while held in reset even though the FSM rests in ISSUE
    assign mem_rd_en       = w_rd_en & reset_n;
    assign mem_addr        = w_addr;
    assign instr_valid     = (r_state == ST_VALID);
    assign instruction     = r_instr;
    assign instr_ext       = r_ext;
    assign instr_two_word  = r_two;
    assign instr_pc        = r_instr_pc;
    assign program_counter = r_pc;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// tb/tb_prog_fetch_unit.sv - directed scoreboard bench for prog_fetch_unit
module tb_prog_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        mem_rd_en;
    logic [13:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [15:0] instr_ext;
    logic        instr_two_word;
    logic [13:0] instr_pc;
    logic        skip_next;
    logic        redirect;
    logic        redirect_rel;
    logic [13:0] redirect_addr;
    logic [11:0] redirect_off;
    logic [13:0] program_counter;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] ext;
        logic        two;
        logic [13:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mem [0:16383];
    int          n_assert = 0;
    int          n_fail   = 0;

    prog_fetch_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .instr_ext       (instr_ext),
        .instr_two_word  (instr_two_word),
        .instr_pc        (instr_pc),
        .skip_next       (skip_next),
        .redirect        (redirect),
        .redirect_rel    (redirect_rel),
        .redirect_addr   (redirect_addr),
        .redirect_off    (redirect_off),
        .program_counter (program_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_instruction", 32'(instruction), 32'(mon_e.ins));
                chk("sb_instr_ext", 32'(instr_ext), 32'(mon_e.ext));
                chk("sb_two_word", 32'(instr_two_word), 32'(mon_e.two));
                chk("sb_instr_pc", 32'(instr_pc), 32'(mon_e.pc));
            end
        end
    end

    task automatic push(input logic [15:0] ins, input logic [15:0] ext, input logic two, input logic [13:0] pc);
        exp_t e;
        e.ins = ins;
        e.ext = ext;
        e.two = two;
        e.pc  = pc;
        sb.push_back(e);
    endtask

    task automatic redirect_abs(input logic [13:0] a);
        redirect      = 1'b1;
        redirect_rel  = 1'b0;
        redirect_addr = a;
        @(posedge clk); #1;
        redirect      = 1'b0;
    endtask

    task automatic wait_valid_pc(input logic [13:0] pc);
        for (int i = 0; i < 40; i++) begin
            if (instr_valid === 1'b1 && instr_pc === pc) break;
            @(posedge clk); #1;
        end
        chk("wait_valid", 32'(instr_valid), 32'd1);
        chk("wait_pc", 32'(instr_pc), 32'(pc));
    endtask

    task automatic drain();
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        instr_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        mem[4]       = 16'hABCD;
        mem[5]       = 16'h2C01;
        mem[6]       = 16'h9100;
        mem[7]       = 16'hBEEF;
        mem[8]       = 16'h5678;
        mem[10]      = 16'h1234;
        mem[20]      = 16'h940C;
        mem[21]      = 16'h0123;
        mem[22]      = 16'h0000;
        mem[16383]   = 16'h940E;
        instr_ready   = 1'b1;
        skip_next     = 1'b0;
        redirect      = 1'b0;
        redirect_rel  = 1'b0;
        redirect_addr = 14'h0;
        redirect_off  = 12'h0;
        reset_n       = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_ext", 32'(instr_ext), 32'd0);
        chk("rst_two", 32'(instr_two_word), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_pc", 32'(program_counter), 32'd0);

        // sequential 1-word fetch from reset, latency two cycles after ISSUE
        for (int i = 0; i < 4; i++) push(16'h0000, 16'h0000, 1'b0, 14'(i));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("lat_wait1_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_first_valid", 32'(instr_valid), 32'd1);
        chk("lat_first_pc", 32'(instr_pc), 32'd0);
        drain();

        // 2-word JMP followed by 1-word instruction
        redirect_abs(14'd20);
        push(16'h940C, 16'h0123, 1'b1, 14'd20);
        push(16'h0000, 16'h0000, 1'b0, 14'd22);
        drain();
        chk("jmp_pc_after", 32'(program_counter), 32'd23);

        // back-pressure: outputs frozen, no reads, PC held
        redirect_abs(14'd4);
        wait_valid_pc(14'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instruction", 32'(instruction), 32'hABCD);
            chk("hold_rd_en", 32'(mem_rd_en), 32'd0);
            chk("hold_pc", 32'(program_counter), 32'd4);
        end
        push(16'hABCD, 16'h0000, 1'b0, 14'd4);
        drain();
        chk("hold_pc_after", 32'(program_counter), 32'd5);

        // relative redirect coincident with accept: 10 + 1 - 3 = 8
        redirect_abs(14'd10);
        wait_valid_pc(14'd10);
        push(16'h1234, 16'h0000, 1'b0, 14'd10);
        push(16'h5678, 16'h0000, 1'b0, 14'd8);
        instr_ready  = 1'b1;
        redirect     = 1'b1;
        redirect_rel = 1'b1;
        redirect_off = 12'hFFD;
        @(posedge clk); #1;
        redirect     = 1'b0;
        redirect_rel = 1'b0;
        chk("rel_pc", 32'(program_counter), 32'd8);
        drain();

        // absolute redirect to top of memory with a 2-word instruction wrapping
        mem[0] = 16'h0042;
        mem[1] = 16'h0007;
        redirect_abs(14'h3FFF);
        push(16'h940E, 16'h0042, 1'b1, 14'h3FFF);
        push(16'h0007, 16'h0000, 1'b0, 14'd1);
        drain();
        chk("wrap_pc_after", 32'(program_counter), 32'd2);

        // skip of a 2-word LDS at 6/7
        redirect_abs(14'd5);
        wait_valid_pc(14'd5);
        push(16'h2C01, 16'h0000, 1'b0, 14'd5);
        push(16'h5678, 16'h0000, 1'b0, 14'd8);
        instr_ready = 1'b1;
        skip_next   = 1'b1;
        @(posedge clk); #1;
        skip_next   = 1'b0;
        drain();

        // reset asserted in WAIT2 discards the JMP fetch
        redirect_abs(14'd20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(instr_valid), 32'd0);
        chk("rst_mid_pc", 32'(program_counter), 32'd0);
        chk("rst_mid_rd_en", 32'(mem_rd_en), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        push(16'h0042, 16'h0000, 1'b0, 14'd0);
        drain();

        // redirect in WAIT1 discards the JMP fetch
        redirect_abs(14'd20);
        @(posedge clk); #1;
        redirect_abs(14'd10);
        chk("wait1_redir_valid", 32'(instr_valid), 32'd0);
        push(16'h1234, 16'h0000, 1'b0, 14'd10);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
